// File: rtl/pr_skid_stage_pkg.sv
// Shared pipeline definitions: skid-stage occupancy encoding and the RV32 NOP bubble.
package pr_skid_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    localparam logic [31:0] RV32_NOP = 32'h00000013;

endpackage

// File: rtl/pr_skid_stage_sat_counter.sv
// Saturating up-counter: one per cycle with i_inc high, sticks at all-ones.
// Latency: count visible the cycle after the increment; no backpressure.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_inc,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pr_skid_stage.sv
// Pipeline-register skid stage: main + skid entries, registered ready, flush to bubble.
// Latency 1 cycle when empty; i_in_ready drops only when both entries are full.
module pr_skid_stage
    import pr_skid_stage_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_DATA = DATA_WIDTH'({32'h0, RV32_NOP}),
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    input  logic                  i_flush,
    output logic [CNT_WIDTH-1:0]  o_stall_cnt
);

    skid_state_t           r_state;
    skid_state_t           w_state_nxt;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_main;
    logic [DATA_WIDTH-1:0] r_skid;
    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic                  w_stall;

    assign w_in_xfer  = i_in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & i_out_ready;
    assign w_stall    = r_out_valid & ~i_out_ready;

    // Ready/valid flags are registered from the next state so neither port sees a comb path.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_TWO);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_in_xfer) w_state_nxt = ST_ONE;
                ST_ONE: begin
                    if (w_in_xfer && !w_out_xfer)      w_state_nxt = ST_TWO;
                    else if (!w_in_xfer && w_out_xfer) w_state_nxt = ST_EMPTY;
                end
                ST_TWO:   if (w_out_xfer) w_state_nxt = ST_ONE;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_flush) begin
            r_main <= BUBBLE_DATA;
            r_skid <= BUBBLE_DATA;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_in_xfer) r_main <= i_in_data;
                ST_ONE: begin
                    if (w_in_xfer && w_out_xfer)  r_main <= i_in_data;
                    else if (w_in_xfer)           r_skid <= i_in_data;
                    else if (w_out_xfer)          r_main <= BUBBLE_DATA;
                end
                ST_TWO: begin
                    if (w_out_xfer) begin
                        r_main <= r_skid;
                        r_skid <= BUBBLE_DATA;
                    end
                end
                default: begin
                    r_main <= BUBBLE_DATA;
                    r_skid <= BUBBLE_DATA;
                end
            endcase
        end
    end

    always_comb begin
        o_in_ready  = r_in_ready;
        o_out_valid = r_out_valid;
        o_out_data  = r_main;
    end

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_reset_n),
        .i_inc   (w_stall),
        .o_cnt   (o_stall_cnt)
    );

endmodule

// File: tb/tb_pr_skid_stage.sv
// Directed and randomised checks of pr_skid_stage against hand-computed values and a queue model.
module tb_pr_skid_stage;

    localparam int          DW     = 64;
    localparam int          CW     = 4;
    localparam logic [63:0] BUBBLE = 64'h0000_0000_0000_0013;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          flush;
    logic [CW-1:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    pr_skid_stage #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .i_flush     (flush),
        .o_stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b1);
        tick();
        tick();
    endtask

    // Reference model for the random phase
    logic [63:0] q[$];
    int          m_cnt;

    initial begin
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_data",  out_data,  BUBBLE);
        check("rst_stall_cnt", stall_cnt, 0);

        // Streaming A,B,C
        reset_n = 1'b1;
        drive(1'b1, 64'hA, 1'b1, 1'b0);
        tick();
        check("str_a_valid", out_valid, 1);
        check("str_a_data",  out_data,  64'hA);
        check("str_a_rdy",   in_ready,  1);
        drive(1'b1, 64'hB, 1'b1, 1'b0);
        tick();
        check("str_b_data", out_data, 64'hB);
        check("str_b_rdy",  in_ready, 1);
        drive(1'b1, 64'hC, 1'b1, 1'b0);
        tick();
        check("str_c_data", out_data, 64'hC);
        check("str_c_rdy",  in_ready, 1);
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        check("str_drain_valid", out_valid, 0);
        check("str_drain_data",  out_data,  BUBBLE);
        check("str_stall_cnt",   stall_cnt, 0);

        // Backpressure: D then E with downstream blocked
        drive(1'b1, 64'hD, 1'b0, 1'b0);
        tick();
        check("bp_one_data", out_data,  64'hD);
        check("bp_one_cnt",  stall_cnt, 0);
        drive(1'b1, 64'hE, 1'b0, 1'b0);
        tick();
        check("bp_two_rdy",  in_ready,  0);
        check("bp_two_data", out_data,  64'hD);
        check("bp_two_cnt",  stall_cnt, 1);
        drive(1'b1, 64'hBAD, 1'b0, 1'b0);
        tick();
        check("bp_hold_data", out_data,  64'hD);
        check("bp_hold_cnt",  stall_cnt, 2);
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        tick();
        check("bp_pop1_data", out_data, 64'hE);
        check("bp_pop1_rdy",  in_ready, 1);
        tick();
        check("bp_pop2_valid", out_valid, 0);
        check("bp_pop2_cnt",   stall_cnt, 2);

        // Flush from TWO with a simultaneous input
        drive(1'b1, 64'hF, 1'b0, 1'b0);
        tick();
        drive(1'b1, 64'h6, 1'b0, 1'b0);
        tick();
        check("fl_pre_rdy", in_ready, 0);
        drive(1'b1, 64'hC0C0, 1'b0, 1'b1);
        tick();
        check("fl_valid", out_valid, 0);
        check("fl_data",  out_data,  BUBBLE);
        check("fl_rdy",   in_ready,  1);
        check("fl_cnt",   stall_cnt, 4);
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_no_c", out_valid, 0);
        end

        // Saturation after a fresh reset
        do_reset();
        reset_n = 1'b1;
        drive(1'b1, 64'h55, 1'b0, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("sat_14", stall_cnt, 14);
            if (i == 15) check("sat_15", stall_cnt, 15);
        end
        check("sat_20",     stall_cnt, 15);
        check("sat_stable", out_data,  64'h55);

        // Random traffic against a queue model
        do_reset();
        reset_n = 1'b1;
        q.delete();
        m_cnt = 0;
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic       v, r, f, m_rdy, m_vld;
            logic [63:0] d;
            m_rdy = (q.size() < 2);
            m_vld = (q.size() > 0);
            check("rnd_in_ready",  in_ready,  m_rdy);
            check("rnd_out_valid", out_valid, m_vld);
            check("rnd_out_data",  out_data,  m_vld ? q[0] : BUBBLE);
            check("rnd_stall_cnt", stall_cnt, 64'(m_cnt));
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 49) == 0);
            d = {$urandom, $urandom};
            drive(v, d, r, f);
            if (m_vld && !r && m_cnt < 15) m_cnt++;
            if (f) begin
                q.delete();
            end else begin
                if (m_vld && r) void'(q.pop_front());
                if (v && m_rdy) q.push_back(d);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pr_skid_stage.md
PR_SKID_STAGE -- requirements
Module: pr_skid_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 64, is the payload width (PC and instruction packed, PC in the upper bits).
REQ-002 Parameter BUBBLE_DATA, default {32'h0, 32'h00000013}, is the payload value driven when no valid entry is held.
REQ-003 Parameter CNT_WIDTH, default 16, is the width of the stall counter.
REQ-004 CLK  input  1  is the single clock; all state SHALL update on the rising edge.
REQ-005 RESET_N  input  1  is a synchronous, active-low reset, sampled on the rising edge of CLK.
REQ-006 IN_VALID  input  1  is the upstream payload-valid signal.
REQ-007 IN_READY  output  1  is the stage-can-accept signal, driven directly from a register.
REQ-008 IN_DATA  input  DATA_WIDTH  is the upstream payload.
REQ-009 OUT_VALID  output  1  is the downstream payload-valid signal.
REQ-010 OUT_READY  input  1  is the downstream-can-accept signal.
REQ-011 OUT_DATA  output  DATA_WIDTH  is the downstream payload, driven directly from a register.
REQ-012 FLUSH  input  1  discards all held entries (branch or jump redirect).
REQ-013 STALL_CNT  output  CNT_WIDTH  counts cycles with OUT_VALID=1 and OUT_READY=0, saturating.

Function
REQ-014 A transfer in SHALL occur when IN_VALID and IN_READY are both 1; a transfer out SHALL occur when OUT_VALID and OUT_READY are both 1.
REQ-015 Storage SHALL consist of a main register feeding OUT_DATA and one skid register, with states EMPTY, ONE (main full) and TWO (main and skid full).
REQ-016 EMPTY: a transfer in SHALL load the main register and move to ONE.
REQ-017 ONE: in only -> load skid, go TWO; out only -> go EMPTY; in and out -> load main, stay ONE; neither -> hold.
REQ-018 TWO: a transfer out SHALL move the skid entry into main and go ONE; no transfer in is possible in TWO.
REQ-019 IN_READY SHALL be 1 exactly when the state is not TWO, so upstream never sees a combinational ready path.
REQ-020 Latency from transfer in to OUT_VALID SHALL be 1 cycle when the stage is EMPTY (or ONE with a simultaneous transfer out).
REQ-021 Payload order SHALL be strictly FIFO; no entry is duplicated or dropped except by FLUSH.
REQ-022 OUT_VALID SHALL be 1 exactly in states ONE and TWO.
REQ-023 OUT_DATA SHALL equal BUBBLE_DATA whenever the state is EMPTY.
REQ-024 OUT_DATA SHALL stay stable while OUT_VALID=1 and OUT_READY=0.
REQ-025 FLUSH=1 SHALL override everything else: the next state is EMPTY, OUT_DATA becomes BUBBLE_DATA, and any same-cycle input transfer is discarded.
REQ-026 IN_READY SHALL be 1 in the cycle after a flush.
REQ-027 STALL_CNT SHALL increment by 1 per stall cycle and hold at all-ones when saturated.
REQ-028 STALL_CNT SHALL NOT be cleared by FLUSH.

Reset
REQ-029 With RESET_N=0 at a clock edge, the stage SHALL reset to: state EMPTY, OUT_VALID=0, IN_READY=1, OUT_DATA=BUBBLE_DATA, skid register=BUBBLE_DATA, STALL_CNT=0.
REQ-030 Reset SHALL take priority over FLUSH and over every transfer; any entry in flight during reset is discarded.
REQ-031 The first transfer in SHALL be accepted at the first rising edge after RESET_N returns to 1.

Structure
REQ-032 The state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and the default RV32 NOP constant 32'h00000013 SHALL reside in the shared pipeline package.
REQ-033 The saturating stall counter SHALL be a separate sub-module, sat_counter, parametrised by CNT_WIDTH.
REQ-034 The IF/ID, ID/EX, EX/MEM and MEM/WB stages SHALL be able to instantiate this block by setting DATA_WIDTH and BUBBLE_DATA only.

Verification
REQ-035 Reset: hold RESET_N=0 for 2 cycles with IN_VALID=1 -> OUT_VALID=0, IN_READY=1, OUT_DATA=BUBBLE_DATA, STALL_CNT=0.
REQ-036 Streaming: with OUT_READY=1, drive IN_DATA=A,B,C on consecutive cycles -> OUT_DATA shows A,B,C one cycle later each, and IN_READY stays 1.
REQ-037 Backpressure: send A, then B with OUT_READY=0 -> state TWO and IN_READY=0; raise OUT_READY for 2 cycles -> A then B, and STALL_CNT equals the number of stalled cycles.
REQ-038 Flush: in state TWO, assert FLUSH with IN_VALID=1 and IN_DATA=C -> next cycle OUT_VALID=0, OUT_DATA=BUBBLE_DATA, IN_READY=1, and C never appears at the output.
REQ-039 Saturation: with CNT_WIDTH=4, stall for 20 cycles -> STALL_CNT=15 and holds there.
REQ-040 Random: apply random IN_VALID, OUT_READY and sparse FLUSH for 10k cycles -> the output sequence matches a reference queue model that is cleared on each flush.
